// File: rtl/mdu_seq.sv
// -----------------------------------------------------------------------------
// mdu_seq - multiply/divide sequencer for the MIPS32 EX stage.
//
// Runs iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring divide), owns
// the HI/LO registers and executes MTHI/MTLO. While an operation is in flight
// it raises stall_req whenever EX tries to issue another MDU op or to read
// HI/LO, so the pipeline holds EX until the result lands.
//
// Build option:
//   MDU_FAST_MUL_EN  defined   -> MULT/MULTU use a single-cycle 2W-bit '*'
//                                 (start at E0, result and done at E1).
//                    undefined -> MULT/MULTU iterate W cycles plus a FIX cycle.
//   DIV/DIVU are iterative in both builds; results are identical in both.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   issue mdu_op this cycle (EX valid, not stalled)
//   mdu_op     in   0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NOP
//   op1        in   rs value (multiplicand / dividend / MT source)
//   op2        in   rt value (multiplier / divisor)
//   hilo_read  in   MFHI/MFLO is in EX this cycle
//   busy       out  iterative operation in flight
//   stall_req  out  pipeline must hold EX (combinational)
//   done       out  one-cycle pulse: HI/LO were just updated by MUL/DIV
//   hi, lo     out  HI/LO registers
//
// Handshake: an op is accepted at a rising edge where start=1 and busy=0.
// When start=1 and busy=1 the op is not accepted and stall_req=1; EX holds
// and keeps presenting the same op until an edge where it is accepted.
// hilo_read follows the same rule: the read is valid in a cycle where
// stall_req=0.
// -----------------------------------------------------------------------------
module mdu_seq #(
    parameter int W        = 32,
    parameter int MDU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [W-1:0]        op1,
    input  logic [W-1:0]        op2,
    input  logic                hilo_read,
    output logic                busy,
    output logic                stall_req,
    output logic                done,
    output logic [W-1:0]        hi,
    output logic [W-1:0]        lo
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    localparam logic [MDU_OP_W-1:0] OP_MULT  = MDU_OP_W'(1);
    localparam logic [MDU_OP_W-1:0] OP_MULTU = MDU_OP_W'(2);
    localparam logic [MDU_OP_W-1:0] OP_DIV   = MDU_OP_W'(3);
    localparam logic [MDU_OP_W-1:0] OP_DIVU  = MDU_OP_W'(4);
    localparam logic [MDU_OP_W-1:0] OP_MTHI  = MDU_OP_W'(5);
    localparam logic [MDU_OP_W-1:0] OP_MTLO  = MDU_OP_W'(6);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

`ifdef MDU_FAST_MUL_EN
    // The product is formed at issue, so a multiply goes straight to FIX.
    localparam state_t MUL_ENTRY = S_FIX;
`else
    localparam state_t MUL_ENTRY = S_MUL;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    // Shared working registers:
    //   MUL: {acc_hi, acc_lo} is the running product; acc_lo starts as the
    //        multiplier and is shifted out from the bottom.
    //   DIV: acc_hi is the partial remainder, acc_lo starts as the dividend
    //        and is replaced by quotient bits from the bottom.
    logic [W-1:0] acc_hi;
    logic [W-1:0] acc_lo;
    logic [W-1:0] b_mag;     // multiplicand / divisor magnitude
    logic [W-1:0] op1_q;     // raw dividend, returned as HI on divide by zero
    logic         is_div;
    logic         neg_q;     // negate product / quotient in FIX
    logic         neg_r;     // negate remainder in FIX
    logic         div_zero;

    // ---------------- issue decode ----------------
    logic         accept;
    logic         op_mul;
    logic         op_div;
    logic         op_mthi;
    logic         op_mtlo;
    logic         op_signed;
    logic         a_neg;
    logic         b_neg;
    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag_in;

    assign busy      = (state != S_IDLE);
    assign stall_req = busy & (start | hilo_read);
    assign accept    = start & ~busy;

    assign op_mul    = accept & ((mdu_op == OP_MULT) | (mdu_op == OP_MULTU));
    assign op_div    = accept & ((mdu_op == OP_DIV)  | (mdu_op == OP_DIVU));
    assign op_mthi   = accept & (mdu_op == OP_MTHI);
    assign op_mtlo   = accept & (mdu_op == OP_MTLO);
    assign op_signed = (mdu_op == OP_MULT) | (mdu_op == OP_DIV);

    // Magnitudes fit in W unsigned bits: abs(-2^(W-1)) = 2^(W-1) < 2^W.
    assign a_neg    = op_signed & op1[W-1];
    assign b_neg    = op_signed & op2[W-1];
    assign a_mag    = a_neg ? (~op1 + 1'b1) : op1;
    assign b_mag_in = b_neg ? (~op2 + 1'b1) : op2;

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
    assign fast_prod = {{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag_in};
`endif

    // ---------------- iteration datapath ----------------
    logic [W:0]     mul_sum;
    logic [W:0]     div_shift;
    logic           div_ge;
    logic [W-1:0]   div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(W+1){1'b0}});
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_ge    = (div_shift >= {1'b0, b_mag});
    // When div_ge holds the true difference is below b_mag, so the low W
    // bits of the modular subtraction are exact.
    assign div_diff  = div_shift[W-1:0] - b_mag;

    assign prod_fix  = neg_q ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};
    assign quo_fix   = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_fix   = neg_r ? (~acc_hi + 1'b1) : acc_hi;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_mul) begin
                    state_nxt = MUL_ENTRY;
                end else if (op_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL:   if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_DIV:   if (cnt == CNT_LAST) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            b_mag    <= '0;
            op1_q    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (op_mul || op_div) begin
                        b_mag    <= b_mag_in;
                        op1_q    <= op1;
                        is_div   <= op_div;
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= op_div && (op2 == '0);
                        if (op_div) begin
                            acc_hi <= '0;
                            acc_lo <= a_mag;
                        end else begin
`ifdef MDU_FAST_MUL_EN
                            {acc_hi, acc_lo} <= fast_prod;
`else
                            acc_hi <= '0;
                            acc_lo <= a_mag;
`endif
                        end
                    end else if (op_mthi) begin
                        hi <= op1;
                    end else if (op_mtlo) begin
                        lo <= op1;
                    end
                end
                S_MUL: begin
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[W-1:1]};
                    cnt              <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc_hi <= div_ge ? div_diff : div_shift[W-1:0];
                    acc_lo <= {acc_lo[W-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                end
                S_FIX: begin
                    done <= 1'b1;
                    if (is_div) begin
                        if (div_zero) begin
                            hi <= op1_q;
                            lo <= '1;
                        end else begin
                            // -2^(W-1) / -1 lands here naturally: the
                            // magnitude quotient is 2^(W-1) with a positive
                            // sign, which reads back as 0x8000_0000.
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

    localparam int W = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_NOP7  = 3'd7;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   mdu_op = 3'd0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         hilo_read = 1'b0;
    logic         busy;
    logic         stall_req;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    mdu_seq #(.W(W), .MDU_OP_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mdu_op    (mdu_op),
        .op1       (op1),
        .op2       (op2),
        .hilo_read (hilo_read),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected {hi,lo}.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hilo", {hi, lo}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Presents an op for one edge; afterwards operands are scrambled to show
    // the DUT latched them. Returns at the negedge after the issuing edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        op1    = a;
        op2    = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = OP_NOP;
        op1    = $urandom;
        op2    = $urandom;
    endtask

    // Called at the negedge after the issuing edge; waits for done (bounded).
    task automatic wait_done(input string name, input int lat);
        int cyc;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc - 1), 64'(lat));
        @(negedge clk);
        check({name, "_done_once"}, 64'(done), 64'(0));
        check({name, "_idle_after"}, 64'(busy), 64'(0));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int lat);
        exp_q.push_back({exp_hi, exp_lo});
        issue(op, a, b);
        check({name, "_busy"}, 64'(busy), 64'(1));
        wait_done(name, lat);
    endtask

    // ---------------- stimulus ----------------
    int cyc;
    int stall_cnt;
    int done_cnt;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_stall", 64'(stall_req), 64'(0));
        rst = 1'b0;

        // Directed arithmetic vectors, hand-computed.
        run_op("mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
        run_op("multu_max",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_op("mult_7xneg5",   OP_MULT,  32'd7,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, MUL_LAT);
        run_op("mult_neg4xneg8",OP_MULT,  32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0020, MUL_LAT);
        run_op("mult_minxmin",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT);
        run_op("div_neg7by2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("divu_100by7",   OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        DIV_LAT);
        run_op("div_7byneg2",   OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT);
        run_op("div_neg8byneg3",OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,         DIV_LAT);
        run_op("divu_big",      OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, DIV_LAT);
        run_op("div_by_zero",   OP_DIV,   32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, DIV_LAT);
        run_op("div_overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_LAT);

        // hilo_read while a DIV is in flight: stall every busy cycle, then release.
        exp_q.push_back({32'd1, 32'd333});
        issue(OP_DIVU, 32'd1000, 32'd3);
        hilo_read = 1'b1;
        #1;
        stall_cnt = 0;
        cyc = 1;
        while (!done && cyc < 200) begin
            if (stall_req) stall_cnt++;
            @(negedge clk);
            cyc++;
        end
        check("hazard_stall_cycles", 64'(stall_cnt), 64'(DIV_LAT));
        check("hazard_stall_at_done", 64'(stall_req), 64'(0));
        hilo_read = 1'b0;
        @(negedge clk);

        // MTHI presented while busy: held off, applied once the unit is idle.
        exp_q.push_back({32'd2, 32'd14});
        issue(OP_DIVU, 32'd100, 32'd7);
        start  = 1'b1;
        mdu_op = OP_MTHI;
        op1    = 32'hAA;
        #1;
        check("mthi_busy_stall", 64'(stall_req), 64'(1));
        cyc = 1;
        while (stall_req && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("mthi_release_cycle", 64'(cyc), 64'(DIV_LAT + 1));
        check("mthi_not_early", 64'(hi), 64'(32'd2));
        @(negedge clk);
        start  = 1'b0;
        mdu_op = OP_NOP;
        #1;
        check("mthi_hi", 64'(hi), 64'(32'hAA));
        check("mthi_lo_kept", 64'(lo), 64'(32'd14));
        check("mthi_no_done", 64'(done), 64'(0));

        // MTLO from idle.
        issue(OP_MTLO, 32'h55, 32'd0);
        check("mtlo_lo", {hi, lo}, {32'hAA, 32'h55});
        check("mtlo_not_busy", 64'(busy), 64'(0));
        check("mtlo_no_done", 64'(done), 64'(0));

        // NOP encodings do nothing.
        issue(OP_NOP, 32'h1, 32'h2);
        check("nop0_not_busy", 64'(busy), 64'(0));
        issue(OP_NOP7, 32'h3, 32'h4);
        check("nop7_not_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("nop_hilo_kept", {hi, lo}, {32'hAA, 32'h55});
        check("nop_no_done", 64'(done), 64'(0));

        // Reset part-way through a DIV: everything clears, no done pulse.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_hilo", {hi, lo}, 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        run_op("multu_5x6", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, MUL_LAT);

        // start together with hilo_read in idle: read not stalled, sees old values.
        exp_q.push_back({32'd0, 32'd12});
        @(negedge clk);
        start     = 1'b1;
        mdu_op    = OP_MULTU;
        op1       = 32'd3;
        op2       = 32'd4;
        hilo_read = 1'b1;
        #1;
        check("idle_read_no_stall", 64'(stall_req), 64'(0));
        check("idle_read_old_hilo", {hi, lo}, {32'd0, 32'd30});
        @(negedge clk);
        start     = 1'b0;
        mdu_op    = OP_NOP;
        hilo_read = 1'b0;
        check("idle_read_op_busy", 64'(busy), 64'(1));
        wait_done("multu_3x4", MUL_LAT);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
